// File: rtl/wbcarbiter_if.sv
// Bus bundle for the Wishbone classic N-to-1 arbiter. Per-master signals are
// packed and concatenated, and master m occupies slice m.
interface wbcarbiter_if #(
  parameter int NM = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic [NM-1:0]    i_mcyc;
  logic [NM-1:0]    i_mstb;
  logic [NM-1:0]    i_mwe;
  logic [NM*AW-1:0] i_maddr;
  logic [NM*DW-1:0] i_mdata;
  logic [NM*SW-1:0] i_msel;
  logic [NM-1:0]    o_mack;
  logic [NM*DW-1:0] o_mdata;
  logic [NM-1:0]    o_merr;

  logic             o_scyc;
  logic             o_sstb;
  logic             o_swe;
  logic [AW-1:0]    o_saddr;
  logic [DW-1:0]    o_sdata;
  logic [SW-1:0]    o_ssel;
  logic             i_sack;
  logic             i_serr;
  logic [DW-1:0]    i_sdata;

  // Environment side: drives the masters' requests and the slave's responses.
  modport master (
    output i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
    output i_sack, i_serr, i_sdata,
    input  o_mack, o_mdata, o_merr,
    input  o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel
  );

  // Arbiter side.
  modport slave (
    input  i_mcyc, i_mstb, i_mwe, i_maddr, i_mdata, i_msel,
    input  i_sack, i_serr, i_sdata,
    output o_mack, o_mdata, o_merr,
    output o_scyc, o_sstb, o_swe, o_saddr, o_sdata, o_ssel
  );
endinterface

// File: rtl/wbcarbiter.sv
// Wishbone classic arbiter: round-robin grant of NM masters onto one slave,
// bus locked for the whole cyc, with a stalled-strobe watchdog.
module wbcarbiter #(
  parameter int NM      = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int SW      = DW / 8,
  parameter int TIMEOUT = 255
) (
  input  logic         i_clk,
  input  logic         i_reset,
  wbcarbiter_if.slave  bus
);

  localparam int          GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int          WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned NMU = NM;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t         state;
  logic [GW-1:0]  g;
  logic [GW-1:0]  last;
  logic [GW-1:0]  next_g;
  logic [GW-1:0]  cand;
  logic           found;
  logic [WW-1:0]  wd;
  logic           wdfire;
  logic           granted;

  logic           sel_cyc;
  logic           sel_stb;
  logic           sel_we;
  logic [AW-1:0]  sel_addr;
  logic [DW-1:0]  sel_data;
  logic [SW-1:0]  sel_sel;

  logic           scyc;
  logic           sstb;
  logic [NM-1:0]  mack;
  logic [NM-1:0]  merr;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    next_g = last;
    found  = 1'b0;
    cand   = '0;
    for (int unsigned i = 1; i <= NMU; i++) begin
      cand = GW'((32'(last) + i) % NMU);
      for (int unsigned m = 0; m < NMU; m++) begin
        if (!found && cand == GW'(m) && bus.i_mcyc[m]) begin
          found  = 1'b1;
          next_g = cand;
        end
      end
    end
  end

  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_sel  = '0;
    for (int unsigned m = 0; m < NMU; m++) begin
      if (g == GW'(m)) begin
        sel_cyc  = bus.i_mcyc[m];
        sel_stb  = bus.i_mstb[m];
        sel_we   = bus.i_mwe[m];
        sel_addr = bus.i_maddr[m*AW +: AW];
        sel_data = bus.i_mdata[m*DW +: DW];
        sel_sel  = bus.i_msel[m*SW +: SW];
      end
    end
  end

  assign granted = (state == GRANT);
  assign wdfire  = (TIMEOUT != 0) && granted && (wd == WW'(TIMEOUT));
  assign scyc    = granted & sel_cyc;
  // Strobe and responses are also gated by cyc so an owner that abandons a
  // cycle mid-strobe never sees a late ack or error.
  assign sstb    = scyc & sel_stb & ~wdfire;

  always_comb begin
    mack = '0;
    merr = '0;
    if (scyc) begin
      for (int unsigned m = 0; m < NMU; m++) begin
        if (g == GW'(m)) begin
          mack[m] = bus.i_sack & ~wdfire;
          merr[m] = (bus.i_serr & ~wdfire) | wdfire;
        end
      end
    end
  end

  assign bus.o_scyc  = scyc;
  assign bus.o_sstb  = sstb;
  assign bus.o_swe   = scyc & sel_we;
  assign bus.o_saddr = scyc ? sel_addr : '0;
  assign bus.o_sdata = scyc ? sel_data : '0;
  assign bus.o_ssel  = scyc ? sel_sel : '0;
  assign bus.o_mack  = mack;
  assign bus.o_merr  = merr;
  assign bus.o_mdata = {NM{bus.i_sdata}};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      g     <= '0;
      last  <= GW'(NM - 1);
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (|bus.i_mcyc) begin
            g     <= next_g;
            last  <= next_g;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!sel_cyc) begin
            state <= IDLE;
            wd    <= '0;
          end else if (TIMEOUT != 0 && sstb && !bus.i_sack && !bus.i_serr) begin
            if (wd != WW'(TIMEOUT))
              wd <= wd + 1'b1;
          end else begin
            wd <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
